// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 board-side I/O responder.
//   word_t          : 16-bit bus word
//   IO_ADDR_DEFAULT : address decoded as the switch / hex-display port
package slc3_io_pkg;

  typedef logic [15:0] word_t;

  localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

  // Index of each push-button inside the conditioner instance array.
  localparam int BTN_RUN  = 0;
  localparam int BTN_CONT = 1;
  localparam int NUM_BTNS = 2;

endpackage

// File: rtl/slc3_io_responder_button_conditioner.sv
// button_conditioner: conditions one raw active-low push-button.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   btn_n  in  raw button level, active low, asynchronous to clk
//   pulse  out one-cycle pulse per debounced press (stable level 1->0)
// Path: 2-FF synchronizer -> debounce counter -> registered press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      meta  <= btn_n;
      sync  <= meta;
      pulse <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= '0;
        // Levels differ here, so a currently-released stable level means
        // this flip is a press; releases never pulse.
        pulse  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/slc3_io_responder.sv
// slc3_io_responder: board-side responder between the SLC-3 memory bus and SRAM.
//   Clk, Reset            clock, asynchronous active-low reset
//   Run_n, Continue_n     raw active-low buttons -> Run_pulse, Continue_pulse
//   S                     raw switches, synchronized and returned on I/O reads
//   ADDR, CE_n, OE_n, WE_n, Data_from_CPU   CPU memory bus
//   Data_from_SRAM        SRAM read data
//   Data_to_CPU           read data to the MDR mux (switches or SRAM)
//   SRAM_WE_n             SRAM write enable, masked for I/O writes
//   Hex_data, Hex_wr      latched hex word and first-cycle write strobe
module slc3_io_responder
  import slc3_io_pkg::*;
#(
  parameter word_t IO_ADDR         = IO_ADDR_DEFAULT,
  parameter int    DEBOUNCE_CYCLES = 4
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  Run_n,
  input  logic  Continue_n,
  input  word_t S,
  input  word_t ADDR,
  input  logic  CE_n,
  input  logic  OE_n,
  input  logic  WE_n,
  input  word_t Data_from_CPU,
  input  word_t Data_from_SRAM,
  output word_t Data_to_CPU,
  output logic  SRAM_WE_n,
  output logic  Run_pulse,
  output logic  Continue_pulse,
  output word_t Hex_data,
  output logic  Hex_wr
);

  logic [NUM_BTNS-1:0] btn_n;
  logic [NUM_BTNS-1:0] btn_pulse;

  assign btn_n[BTN_RUN]  = Run_n;
  assign btn_n[BTN_CONT] = Continue_n;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTNS-1:0] (
    .clk   (Clk),
    .rst_n (Reset),
    .btn_n (btn_n),
    .pulse (btn_pulse)
  );

  assign Run_pulse      = btn_pulse[BTN_RUN];
  assign Continue_pulse = btn_pulse[BTN_CONT];

  // Switches: plain 2-FF synchronizer, no debounce.
  word_t s_meta;
  word_t s_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= S;
      s_sync <= s_meta;
    end
  end

  // Address decode; write wins when OE_n and WE_n are both low.
  logic io_hit;
  logic io_rd;
  logic io_wr;

  assign io_hit = (ADDR == IO_ADDR) && !CE_n;
  assign io_rd  = io_hit && !OE_n && WE_n;
  assign io_wr  = io_hit && !WE_n;

  assign Data_to_CPU = io_rd ? s_sync : Data_from_SRAM;
  assign SRAM_WE_n   = WE_n | io_hit;

  // Hex register follows every write edge; Hex_wr marks only the first
  // edge of a held write strobe.
  logic wr_prev;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hex_data <= '0;
      Hex_wr   <= 1'b0;
      wr_prev  <= 1'b0;
    end else begin
      wr_prev <= io_wr;
      Hex_wr  <= io_wr && !wr_prev;
      if (io_wr) Hex_data <= Data_from_CPU;
    end
  end

endmodule

// File: tb/tb_slc3_io_responder.sv
module tb_slc3_io_responder;

  localparam int DC = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run_n = 1'b1, Continue_n = 1'b1;
  logic [15:0] S = '0, ADDR = '0, Data_from_CPU = '0, Data_from_SRAM = '0;
  logic        CE_n = 1'b1, OE_n = 1'b1, WE_n = 1'b1;
  logic [15:0] Data_to_CPU, Hex_data;
  logic        SRAM_WE_n, Run_pulse, Continue_pulse, Hex_wr;

  slc3_io_responder #(.IO_ADDR(16'hFFFF), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .Run_n(Run_n), .Continue_n(Continue_n), .S(S),
    .ADDR(ADDR), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
    .Data_from_CPU(Data_from_CPU), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_CPU(Data_to_CPU), .SRAM_WE_n(SRAM_WE_n), .Run_pulse(Run_pulse),
    .Continue_pulse(Continue_pulse), .Hex_data(Hex_data), .Hex_wr(Hex_wr)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Switch path is a two-sample delay line. Each button remembers the raw
  // samples of the last two edges; the debounced level flips once the
  // synchronized level has disagreed with it for DC consecutive samples.
  logic [15:0] s_dly[2];
  logic        b_dly[2][2];
  logic        b_lvl[2];
  int          b_disagree[2];
  logic        b_pulse[2];
  logic [15:0] m_hex;
  logic        m_hexwr, m_wprev;

  function automatic void model_reset();
    s_dly[0] = '0; s_dly[1] = '0;
    for (int b = 0; b < 2; b++) begin
      b_dly[b][0] = 1'b1; b_dly[b][1] = 1'b1;
      b_lvl[b] = 1'b1; b_disagree[b] = 0; b_pulse[b] = 1'b0;
    end
    m_hex = '0; m_hexwr = 1'b0; m_wprev = 1'b0;
  endfunction

  function automatic logic m_io_hit();
    return (ADDR == 16'hFFFF) && !CE_n;
  endfunction

  function automatic void model_edge();
    logic raw[2];
    logic io_w;
    raw[0] = Run_n; raw[1] = Continue_n;
    for (int b = 0; b < 2; b++) begin
      logic seen;
      seen = b_dly[b][1];           // level the debouncer sees on this edge
      b_pulse[b] = 1'b0;
      if (seen != b_lvl[b]) begin
        b_disagree[b]++;
        if (b_disagree[b] == DC) begin
          b_pulse[b] = (seen == 1'b0);
          b_lvl[b] = seen;
          b_disagree[b] = 0;
        end
      end else b_disagree[b] = 0;
      b_dly[b][1] = b_dly[b][0];
      b_dly[b][0] = raw[b];
    end
    s_dly[1] = s_dly[0];
    s_dly[0] = S;
    io_w = m_io_hit() && !WE_n;
    if (io_w) m_hex = Data_from_CPU;
    m_hexwr = io_w && !m_wprev;
    m_wprev = io_w;
  endfunction

  function automatic logic [15:0] exp_rd();
    return (m_io_hit() && !OE_n && WE_n) ? s_dly[1] : Data_from_SRAM;
  endfunction

  int n_tick = 0, run_cnt = 0, cont_cnt = 0;
  int run_first = -1, cont_first = -1;

  task automatic check_all();
    chk("hex_data", Hex_data, m_hex);
    chk("hex_wr", Hex_wr, m_hexwr);
    chk("run_pulse", Run_pulse, b_pulse[0]);
    chk("cont_pulse", Continue_pulse, b_pulse[1]);
    chk("data_to_cpu", Data_to_CPU, exp_rd());
    chk("sram_we_n", SRAM_WE_n, WE_n | m_io_hit());
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle.
  task automatic tick();
    @(posedge Clk);
    if (Reset) model_edge(); else model_reset();
    @(negedge Clk);
    n_tick++;
    check_all();
    if (Run_pulse) begin run_cnt++; if (run_first < 0) run_first = n_tick; end
    if (Continue_pulse) begin cont_cnt++; if (cont_first < 0) cont_first = n_tick; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input logic [15:0] a, input logic ce, input logic oe, input logic we,
                     input logic [15:0] din, input logic [15:0] sram);
    ADDR = a; CE_n = ce; OE_n = oe; WE_n = we; Data_from_CPU = din; Data_from_SRAM = sram;
  endtask

  task automatic idle_bus();
    bus(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
  endtask

  int rc, cc, t0;

  initial begin
    model_reset();
    // 1. reset with a press and an I/O write active
    #1;
    Continue_n = 1'b0;
    bus(16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000);
    Reset = 1'b0;
    #1;
    chk("rst_hex", Hex_data, 16'h0000);
    chk("rst_hexwr", Hex_wr, 1'b0);
    chk("rst_cont", Continue_pulse, 1'b0);
    chk("rst_run", Run_pulse, 1'b0);
    ticks(3);
    idle_bus();
    @(negedge Clk);
    Reset = 1'b1;
    t0 = n_tick; cont_first = -1;
    ticks(10);
    chk("rst_cont_lat", cont_first - t0, 6);
    Continue_n = 1'b1; ticks(10);

    // 2. long hold, one pulse, no pulse on release
    cc = cont_cnt; t0 = n_tick; cont_first = -1;
    Continue_n = 1'b0; ticks(20);
    chk("hold_one_pulse", cont_cnt - cc, 1);
    chk("hold_latency", cont_first - t0, 6);
    cc = cont_cnt;
    Continue_n = 1'b1; ticks(10);
    chk("release_no_pulse", cont_cnt - cc, 0);

    // 3. short glitch, then simultaneous presses
    rc = run_cnt;
    Run_n = 1'b0; ticks(3); Run_n = 1'b1; ticks(10);
    chk("glitch_no_pulse", run_cnt - rc, 0);
    rc = run_cnt; cc = cont_cnt; run_first = -1; cont_first = -1;
    Run_n = 1'b0; Continue_n = 1'b0; ticks(10);
    chk("both_run", run_cnt - rc, 1);
    chk("both_cont", cont_cnt - cc, 1);
    chk("both_same_cycle", run_first, cont_first);
    Run_n = 1'b1; Continue_n = 1'b1; ticks(10);

    // 4. switch read latency and SRAM pass-through
    bus(16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h7777);
    S = 16'h000B;
    tick();
    chk("s_rd_1edge", Data_to_CPU, 16'h0000);
    tick();
    chk("s_rd_2edge", Data_to_CPU, 16'h000B);
    bus(16'h3000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
    #1 chk("sram_rd", Data_to_CPU, 16'h1234);
    tick();

    // 5. held I/O write, then an SRAM write
    bus(16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hA0A0, 16'h0000);
    #1 chk("io_wr_sram_we", SRAM_WE_n, 1'b1);
    tick();
    chk("io_wr_hex", Hex_data, 16'hA0A0);
    chk("io_wr_strobe", Hex_wr, 1'b1);
    tick();
    chk("io_wr_strobe_once", Hex_wr, 1'b0);
    tick();
    idle_bus(); tick();
    bus(16'h3000, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0000);
    #1 chk("mem_wr_sram_we", SRAM_WE_n, 1'b0);
    tick();
    chk("mem_wr_hex_hold", Hex_data, 16'hA0A0);
    idle_bus(); tick();

    // 6. step/write flow
    cc = cont_cnt;
    for (int k = 1; k <= 8; k++) begin
      Continue_n = 1'b0; ticks(8);
      Continue_n = 1'b1; ticks(8);
      bus(16'hFFFF, 1'b0, 1'b1, 1'b0, 16'(k), 16'h0000); tick();
      idle_bus(); tick();
      chk("flow_hex", Hex_data, 32'(k));
    end
    chk("flow_pulses", cont_cnt - cc, 8);

    // Random: buttons held for random spans, bus traffic every cycle.
    begin
      int hold_r = 0, hold_c = 0;
      for (int i = 0; i < 1500; i++) begin
        if (hold_r == 0) begin Run_n = $urandom_range(1, 0); hold_r = $urandom_range(9, 1); end
        if (hold_c == 0) begin Continue_n = $urandom_range(1, 0); hold_c = $urandom_range(9, 1); end
        hold_r--; hold_c--;
        if ($urandom_range(3, 0) == 0) S = 16'($urandom);
        case ($urandom_range(2, 0))
          0: ADDR = 16'hFFFF;
          1: ADDR = 16'h3000;
          default: ADDR = 16'($urandom);
        endcase
        CE_n = ($urandom_range(3, 0) == 0);
        OE_n = $urandom_range(1, 0);
        WE_n = $urandom_range(1, 0);
        Data_from_CPU = 16'($urandom);
        Data_from_SRAM = 16'($urandom);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
